down_counter_timer: RTL

//  Loadable 16-bit down-counter/timer. Companion to the free-running up counter.
//  - Counts a programmed value down to zero at a prescaled tick rate.
//  - Flags terminal count with a one-cycle pulse and a sticky interrupt.
//  - Either stops at zero (one-shot) or reloads (periodic).
//  - Serves as the timeout/interval source for the lab designs.

---
 rtl/down_counter_timer_pkg.sv | 16 +
 rtl/down_counter_timer_if.sv | 35 +++
 rtl/down_counter_timer_prescaler.sv | 39 +++
 rtl/down_counter_timer.sv | 77 +++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer.
//  - state_t        : controller state (IDLE / RUN / DONE)
//  - WIDTH_DEF      : default counter and load-value width
//  - PRESCALE_W_DEF : default prescaler divide-control width
package down_counter_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // out of reset, nothing loaded yet
    RUN  = 2'd1,  // counting down
    DONE = 2'd2   // one-shot expired, count parked at zero
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down-counter/timer.
//  master : the block that programs the timer (drives load, load_value,
//           enable, auto_reload, prescale, irq_clr; observes status)
//  slave  : the timer itself (drives count, zero, tc_pulse, irq, busy)
interface down_counter_timer_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
);

  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic                  enable;
  logic                  auto_reload;
  logic [PRESCALE_W-1:0] prescale;
  logic                  irq_clr;

  logic [WIDTH-1:0]      count;
  logic                  zero;
  logic                  tc_pulse;
  logic                  irq;
  logic                  busy;

  modport master (
    output load, load_value, enable, auto_reload, prescale, irq_clr,
    input  count, zero, tc_pulse, irq, busy
  );

  modport slave (
    input  load, load_value, enable, auto_reload, prescale, irq_clr,
    output count, zero, tc_pulse, irq, busy
  );

endinterface

// File: rtl/down_counter_timer_prescaler.sv
// Tick prescaler: emits one tick every prescale+1 enabled cycles.
//  clk, reset_n : clock, asynchronous active-low reset
//  clr          : restart the divider from zero (wins over en)
//  en           : advance the divider this cycle
//  prescale     : divide control, compared live against the divider
//  tick         : combinational, high on the enabled cycle that wraps
module tick_prescaler
  import down_counter_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // Equality compare only: if prescale drops below cnt, the divider has to
  // roll over through 2^PRESCALE_W before it can match again.
  assign tick = en && (cnt == prescale);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaled tick, terminal-count pulse,
// sticky interrupt, and one-shot or periodic operation.
//  clk     : clock, all state changes on its rising edge
//  reset_n : asynchronous active-low reset
//  bus     : slave side of down_counter_timer_if
//            (load/load_value/enable/auto_reload/prescale/irq_clr in,
//             count/zero/tc_pulse/irq/busy out)
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input logic                clk,
  input logic                reset_n,
  down_counter_timer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             irq_q;
  logic             tick;
  logic             tc_evt;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.load),
    .en       (bus.enable && (state == RUN)),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // A load on the same cycle swallows the terminal count entirely.
  assign tc_evt = tick && !bus.load && (count_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tc_q <= tc_evt;

      // Set beats clear when both land on the same cycle.
      if (tc_evt)           irq_q <= 1'b1;
      else if (bus.irq_clr) irq_q <= 1'b0;

      if (bus.load) begin
        count_q  <= bus.load_value;
        reload_q <= bus.load_value;
        state    <= RUN;
      end else if (tick) begin
        if (count_q != '0) begin
          count_q <= count_q - 1'b1;
        end else if (bus.auto_reload) begin
          count_q <= reload_q;
        end else begin
          state <= DONE;
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.tc_pulse = tc_q;
  assign bus.irq      = irq_q;
  assign bus.busy     = (state == RUN);

endmodule
